// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared state type and counter sizing helper for the SR bank driver
// Purpose: FSM state encoding and the width rule for the shared pulse/settle counter.
// Ports: none (package).
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } sr_state_t;

    // One counter serves both DRIVE and SETTLE, so it is sized for the longer of the two.
    function automatic int sr_cnt_width(input int pulse_cycles, input int settle_cycles);
        int longest;
        longest = (pulse_cycles > settle_cycles) ? pulse_cycles : settle_cycles;
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// rtl/sr_pulse_timer.sv - loadable down-counter with expired flag
// Purpose: times the pulse and settle phases; reloaded on every state entry.
// Ports:
//  clk, rst  clock and asynchronous active-high reset
//  load      load load_val this edge (takes priority over counting)
//  load_val  remaining cycles minus one
//  expired   count has reached zero (current phase ends this cycle)
module sr_pulse_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // Holds at zero rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sr_bank_driver.sv
// rtl/sr_bank_driver.sv - converts target-value requests into s/r pulses for an SR flip-flop bank
// Purpose: pulses only bits that must change, waits a settle time, checks q feedback.
// Ports:
//  clk, rst            clock and asynchronous active-high reset
//  req_valid/ready     request handshake; req_data is the target bank value
//  s_out, r_out        registered set/reset pulses to the bank (never both on one bit)
//  q_fb                bank readback
//  shadow              last committed target
//  done                one-cycle completion pulse
//  err, err_bits       sticky mismatch flag and per-bit history; err_clr clears them
module sr_bank_driver
    import sr_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int PULSE_CYCLES  = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] shadow,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits,
    input  logic             err_clr
);

    localparam int CNT_W = sr_cnt_width(PULSE_CYCLES, SETTLE_CYCLES);

    sr_state_t        state, next_state;
    logic             synced;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] set_m, rst_m;
    logic [WIDTH-1:0] s_next, r_next;
    logic [WIDTH-1:0] chk_target, mism;
    logic             accept, check;
    logic             tmr_load, tmr_expired;
    logic [CNT_W-1:0] tmr_val;

    sr_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Until one check has completed the bank contents are unknown, so every bit is driven.
    always_comb begin
        if (synced) begin
            set_m = req_data & ~shadow;
            rst_m = ~req_data & shadow;
        end else begin
            set_m = req_data;
            rst_m = ~req_data;
        end
    end

    // The no-change path checks on the accept edge, before target is loaded.
    assign chk_target = accept ? req_data : target;
    assign mism       = q_fb ^ chk_target;

    assign req_ready = (state == IDLE);
    assign done      = (state == DONE);

    always_comb begin
        next_state = state;
        s_next     = '0;
        r_next     = '0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        accept     = 1'b0;
        check      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if ((set_m | rst_m) != '0) begin
                        next_state = DRIVE;
                        s_next     = set_m;
                        r_next     = rst_m;
                        tmr_load   = 1'b1;
                        tmr_val    = CNT_W'(PULSE_CYCLES - 1);
                    end else begin
                        next_state = DONE;
                        check      = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (tmr_expired) begin
                    if (SETTLE_CYCLES == 0) begin
                        next_state = DONE;
                        check      = 1'b1;
                    end else begin
                        next_state = SETTLE;
                        tmr_load   = 1'b1;
                        tmr_val    = CNT_W'(SETTLE_CYCLES - 1);
                    end
                end else begin
                    s_next = s_out;
                    r_next = r_out;
                end
            end
            SETTLE: begin
                if (tmr_expired) begin
                    next_state = DONE;
                    check      = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            s_out    <= '0;
            r_out    <= '0;
            target   <= '0;
            shadow   <= '0;
            synced   <= 1'b0;
            err      <= 1'b0;
            err_bits <= '0;
        end else begin
            state <= next_state;
            s_out <= s_next;
            r_out <= r_next;
            if (accept) begin
                target <= req_data;
            end
            if (check) begin
                shadow <= chk_target;
                synced <= 1'b1;
            end
            // A mismatch recorded on the clearing edge survives the clear.
            if (err_clr) begin
                err_bits <= check ? mism : '0;
                err      <= check && (mism != '0);
            end else if (check) begin
                err_bits <= err_bits | mism;
                err      <= err | (mism != '0);
            end
        end
    end

endmodule

// File: tb/tb_sr_bank_driver.sv
// tb/tb_sr_bank_driver.sv - self-checking bench for sr_bank_driver with an SR bank model
module tb_sr_bank_driver;

    localparam int P = 1;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_data = 8'h00;
    logic [7:0] s_out, r_out, q_fb, shadow, err_bits;
    logic       done, err;
    logic       err_clr = 1'b0;

    logic [7:0] bank;
    logic [7:0] stuck0 = 8'h00;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sr_bank_driver #(.WIDTH(8), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .s_out     (s_out),
        .r_out     (r_out),
        .q_fb      (q_fb),
        .shadow    (shadow),
        .done      (done),
        .err       (err),
        .err_bits  (err_bits),
        .err_clr   (err_clr)
    );

    // External SR flip-flop bank; bits in stuck0 read back as 0.
    always @(posedge clk) bank <= (bank & ~r_out) | s_out;
    assign q_fb = bank & ~stuck0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Starts and ends on a falling edge; lat = edges from accept to done rising.
    task automatic send(input logic [7:0] d, output logic [7:0] s_seen,
                        output logic [7:0] r_seen, output int lat);
        int t;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_data  = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = 8'($urandom);
        s_seen = s_out;
        r_seen = r_out;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic [7:0] stuck;
        logic [7:0] s;
        logic [7:0] r;
        int         lat;
        logic [7:0] shadow;
        logic       err;
        logic [7:0] eb;
    } vec_t;

    vec_t vt[5];

    logic [7:0] s_seen, r_seen, d, sm, rm, m_shadow;
    logic       m_synced, acc;
    int         lat, cyc, exp_done_cyc, n_acc, n_done;

    initial begin
        vt[0] = '{8'hA5, 8'h00, 8'hA5, 8'h5A, P + S, 8'hA5, 1'b0, 8'h00};
        vt[1] = '{8'hF0, 8'h00, 8'h50, 8'h05, P + S, 8'hF0, 1'b0, 8'h00};
        vt[2] = '{8'hF0, 8'h00, 8'h00, 8'h00, 0,     8'hF0, 1'b0, 8'h00};
        vt[3] = '{8'hF4, 8'h04, 8'h04, 8'h00, P + S, 8'hF4, 1'b1, 8'h04};
        vt[4] = '{8'hF4, 8'h04, 8'h00, 8'h00, 0,     8'hF4, 1'b1, 8'h04};

        bank = 8'($urandom);
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_s", s_out, 0);
        chk("rst_r", r_out, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_bits", err_bits, 0);
        chk("rst_shadow", shadow, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            stuck0 = vt[i].stuck;
            send(vt[i].d, s_seen, r_seen, lat);
            chk($sformatf("v%0d_s", i), s_seen, vt[i].s);
            chk($sformatf("v%0d_r", i), r_seen, vt[i].r);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_ready_in_done", i), req_ready, 0);
            chk($sformatf("v%0d_shadow", i), shadow, vt[i].shadow);
            chk($sformatf("v%0d_err", i), err, vt[i].err);
            chk($sformatf("v%0d_err_bits", i), err_bits, vt[i].eb);
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), done, 0);
            chk($sformatf("v%0d_ready_back", i), req_ready, 1);
        end

        stuck0  = 8'h00;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_err", err, 0);
        chk("clr_err_bits", err_bits, 0);

        // Reset in the middle of a DRIVE pulse.
        req_valid = 1'b1;
        req_data  = 8'h0F;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_rst_s", s_out, 8'h0B);
        chk("pre_rst_r", r_out, 8'hF0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_s", s_out, 0);
        chk("mid_rst_r", r_out, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_shadow", shadow, 0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h0F, s_seen, r_seen, lat);
        chk("post_rst_s", s_seen, 8'h0F);
        chk("post_rst_r", r_seen, 8'hF0);
        chk("post_rst_lat", lat, P + S);
        chk("post_rst_shadow", shadow, 8'h0F);
        @(negedge clk);

        // Random back-to-back requests against a transaction-level model.
        m_shadow = 8'h0F;
        m_synced = 1'b1;
        exp_done_cyc = -1;
        cyc = 0;
        n_acc = 0;
        n_done = 0;
        for (int k = 0; k < 20000 && (n_acc < 500 || cyc <= exp_done_cyc + 2); k++) begin
            req_valid = (n_acc < 500);
            d = 8'($urandom);
            req_data = d;
            acc = req_valid && req_ready;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc) begin
                sm = m_synced ? (d & ~m_shadow) : d;
                rm = m_synced ? (~d & m_shadow) : ~d;
                chk("rnd_s", s_out, sm);
                chk("rnd_r", r_out, rm);
                exp_done_cyc = cyc + (((sm | rm) != 8'h00) ? P + S : 0);
                m_shadow = d;
                m_synced = 1'b1;
                n_acc++;
            end
            chk("rnd_done", done, cyc == exp_done_cyc);
            chk("rnd_ready", req_ready, cyc > exp_done_cyc);
            chk("rnd_sr_overlap", s_out & r_out, 0);
            if (done) n_done++;
        end
        req_valid = 1'b0;
        chk("rnd_accepts", n_acc, 500);
        chk("rnd_done_count", n_done, n_acc);
        chk("rnd_shadow", shadow, m_shadow);
        chk("rnd_err", err, 0);
        chk("rnd_err_bits", err_bits, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
